apb_riscv_timer: RTL

APB slave implementing the RISC-V machine timer (`mtime` plus one `mtimecmp` per hart) for the example SoC. It sits directly downstream of the AHB-Lite-to-APB bridge on the peripheral bus. It consumes the bridge's `paddr/psel/penable/pwrite/pwdata` plus the forwarded `phartid`. It drives one registered timer interrupt per hart into the cores.

---
 rtl/apb_timer_pkg.sv | 30 +++
 rtl/timer_prescaler.sv | 50 +++++
 rtl/apb_riscv_timer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_timer_pkg
//  Description : Shared constants for the APB RISC-V machine timer: register
//                byte offsets, reset values and a DIV sanitising helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_timer_pkg;

    // Offsets are decoded from paddr[7:0] only.
    typedef logic [7:0] reg_off_t;

    localparam reg_off_t TIMER_CTRL      = 8'h00;
    localparam reg_off_t TIMER_DIV       = 8'h04;
    localparam reg_off_t TIMER_MTIME     = 8'h08;
    localparam reg_off_t TIMER_MTIMEH    = 8'h0C;
    localparam reg_off_t TIMER_CMP_BASE  = 8'h10;
    localparam reg_off_t TIMER_CMP_SELF  = 8'h80;
    localparam reg_off_t TIMER_CMP_SELFH = 8'h84;

    localparam logic [63:0] TIMER_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [15:0] TIMER_DIV_RST      = 16'd1;

    // A divide-by-zero is meaningless; store it as divide-by-one.
    function automatic logic [15:0] div_sanitize(input logic [15:0] i_div);
        return (i_div == 16'd0) ? 16'd1 : i_div;
    endfunction

endpackage : apb_timer_pkg
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_prescaler
//  Description : Holds the DIV register and the prescaler count. Emits a
//                one-cycle tick every DIV enabled cycles; that tick advances
//                mtime in the top level.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_en            - CTRL.EN, count advances while high
//                i_div_we        - DIV write strobe (access phase)
//                i_div_wdata     - value written to DIV
//                o_div           - current DIV value (for readback)
//                o_tick          - mtime increment request
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler
    import apb_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_div_we,
    input  logic [15:0] i_div_wdata,
    output logic [15:0] o_div,
    output logic        o_tick
);

    logic [15:0] r_div;
    logic [15:0] r_count;
    logic        w_wrap;

    assign w_wrap = (r_count == (r_div - 16'd1));

    // A DIV write restarts the count, so the old period cannot tick that cycle.
    assign o_tick = i_en & w_wrap & ~i_div_we;
    assign o_div  = r_div;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= TIMER_DIV_RST;
            r_count <= 16'd0;
        end else if (i_div_we) begin
            r_div   <= div_sanitize(i_div_wdata);
            r_count <= 16'd0;
        end else if (i_en) begin
            r_count <= w_wrap ? 16'd0 : (r_count + 16'd1);
        end
    end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/apb_riscv_timer.sv
`default_nettype none
// ============================================================================
//  Module      : apb_riscv_timer
//  Description : APB slave implementing the RISC-V machine timer: a 64-bit
//                mtime counter driven by a prescaler and one 64-bit mtimecmp
//                per hart, each producing a registered level interrupt.
//                Zero wait states; reads are combinational from paddr.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                apbs_psel/penable   - APB select / access phase
//                apbs_pwrite         - 1 = write
//                apbs_paddr          - byte address, bits [7:0] decoded
//                apbs_pwdata         - write data
//                apbs_phartid        - requesting hart (for the SELF alias)
//                apbs_pready         - tied 1
//                apbs_prdata         - read data (0 on error)
//                apbs_pslverr        - error response in the access phase
//                timer_irq           - per-hart machine timer interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_riscv_timer
    import apb_timer_pkg::*;
#(
    parameter int N_HARTS = 2,
    parameter int W_PADDR = 16,
    parameter int W_DATA  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               apbs_psel,
    input  logic               apbs_penable,
    input  logic               apbs_pwrite,
    input  logic [W_PADDR-1:0] apbs_paddr,
    input  logic [W_DATA-1:0]  apbs_pwdata,
    input  logic [31:0]        apbs_phartid,
    output logic               apbs_pready,
    output logic [W_DATA-1:0]  apbs_prdata,
    output logic               apbs_pslverr,
    output logic [N_HARTS-1:0] timer_irq
);

    // Hart index width; the CMP window plus SELF alias at 0x80 limits
    // N_HARTS to 14 within the 8-bit decoded offset space.
    localparam int          W_HIDX    = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;
    localparam logic [8:0]  c_CMP_END = 9'(32'(TIMER_CMP_BASE) + 8 * N_HARTS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               r_en;
    logic [63:0]        r_mtime;
    logic [63:0]        r_cmp [N_HARTS];
    logic [N_HARTS-1:0] r_irq;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [7:0]        w_off;
    logic [7:0]        w_cmp_rel;
    logic              w_err;
    logic              w_hit_ctrl;
    logic              w_hit_div;
    logic              w_hit_mtl;
    logic              w_hit_mth;
    logic              w_hit_cmp;
    logic              w_cmp_hi;
    logic [W_HIDX-1:0] w_cmp_idx;

    assign w_off     = apbs_paddr[7:0];
    assign w_cmp_rel = w_off - TIMER_CMP_BASE;

    always_comb begin
        w_err      = 1'b0;
        w_hit_ctrl = 1'b0;
        w_hit_div  = 1'b0;
        w_hit_mtl  = 1'b0;
        w_hit_mth  = 1'b0;
        w_hit_cmp  = 1'b0;
        w_cmp_hi   = 1'b0;
        w_cmp_idx  = '0;
        if (w_off[1:0] != 2'b00) begin
            w_err = 1'b1;
        end else if (w_off == TIMER_CTRL) begin
            w_hit_ctrl = 1'b1;
        end else if (w_off == TIMER_DIV) begin
            w_hit_div = 1'b1;
        end else if (w_off == TIMER_MTIME) begin
            w_hit_mtl = 1'b1;
        end else if (w_off == TIMER_MTIMEH) begin
            w_hit_mth = 1'b1;
        end else if ((w_off == TIMER_CMP_SELF) || (w_off == TIMER_CMP_SELFH)) begin
            // Alias resolves to the requesting hart; unknown harts error out.
            if (apbs_phartid < 32'(N_HARTS)) begin
                w_hit_cmp = 1'b1;
                w_cmp_idx = apbs_phartid[W_HIDX-1:0];
                w_cmp_hi  = w_off[2];
            end else begin
                w_err = 1'b1;
            end
        end else if (({1'b0, w_off} >= {1'b0, TIMER_CMP_BASE}) &&
                     ({1'b0, w_off} <  c_CMP_END)) begin
            // Each hart owns an 8-byte slot: low word at +0, high at +4.
            w_hit_cmp = 1'b1;
            w_cmp_idx = w_cmp_rel[3 +: W_HIDX];
            w_cmp_hi  = w_off[2];
        end else begin
            w_err = 1'b1;
        end
    end

    // Writes commit only in the access phase and never on an errored access.
    logic w_wr;
    assign w_wr = apbs_psel & apbs_penable & apbs_pwrite & ~w_err;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic        w_tick;
    logic [15:0] w_div;

    timer_prescaler u_prescaler (
        .clk         (clk),
        .rst         (rst),
        .i_en        (r_en),
        .i_div_we    (w_wr & w_hit_div),
        .i_div_wdata (apbs_pwdata[15:0]),
        .o_div       (w_div),
        .o_tick      (w_tick)
    );

    // ------------------------------------------------------------------
    // CTRL and mtime
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en <= 1'b0;
        end else if (w_wr & w_hit_ctrl) begin
            r_en <= apbs_pwdata[0];
        end
    end

    // A software write to either half wins over a tick in the same cycle;
    // that increment is dropped rather than deferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime <= 64'd0;
        end else if (w_wr & w_hit_mtl) begin
            r_mtime[31:0] <= apbs_pwdata;
        end else if (w_wr & w_hit_mth) begin
            r_mtime[63:32] <= apbs_pwdata;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // ------------------------------------------------------------------
    // mtimecmp registers and interrupts
    // ------------------------------------------------------------------
    logic [N_HARTS-1:0] w_cmp_ge;

    for (genvar h = 0; h < N_HARTS; h++) begin : g_harts
        assign w_cmp_ge[h] = (r_mtime >= r_cmp[h]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int h = 0; h < N_HARTS; h++) begin
                r_cmp[h] <= TIMER_MTIMECMP_RST;
            end
            r_irq <= '0;
        end else begin
            for (int h = 0; h < N_HARTS; h++) begin
                if (w_wr && w_hit_cmp && (w_cmp_idx == W_HIDX'(h))) begin
                    if (w_cmp_hi) begin
                        r_cmp[h][63:32] <= apbs_pwdata;
                    end else begin
                        r_cmp[h][31:0] <= apbs_pwdata;
                    end
                end
            end
            r_irq <= w_cmp_ge;
        end
    end

    assign timer_irq = r_irq;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [W_DATA-1:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        if (w_hit_ctrl) begin
            w_rdata = {31'd0, r_en};
        end else if (w_hit_div) begin
            w_rdata = {16'd0, w_div};
        end else if (w_hit_mtl) begin
            w_rdata = r_mtime[31:0];
        end else if (w_hit_mth) begin
            w_rdata = r_mtime[63:32];
        end else if (w_hit_cmp) begin
            w_rdata = w_cmp_hi ? r_cmp[w_cmp_idx][63:32] : r_cmp[w_cmp_idx][31:0];
        end
    end

    assign apbs_pready  = 1'b1;
    assign apbs_prdata  = apbs_psel ? w_rdata : '0;
    assign apbs_pslverr = apbs_psel & apbs_penable & w_err;

    // Address bits above the decoded byte and the unused slices of the
    // relative CMP offset are intentionally ignored.
    logic w_unused;
    assign w_unused = ^{apbs_paddr[W_PADDR-1:8], w_cmp_rel};

endmodule : apb_riscv_timer
`default_nettype wire
